// File: rtl/cav_lock_seq.sv
// Lock-acquisition sequencer for one cavity servo integrator: ramps NI, declares lock,
// detects rail/large-error loss of lock, clears the integrator and re-acquires.
module cav_lock_seq #(
   parameter int SIGNAL_SIZE = 25,
   parameter int CW          = 20,
   parameter int NI_STEP     = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          hold_req,
   input  logic signed [SIGNAL_SIZE-1:0] s_err,
   input  logic signed [SIGNAL_SIZE-1:0] s_out,
   input  logic signed [SIGNAL_SIZE-1:0] UL,
   input  logic signed [SIGNAL_SIZE-1:0] LL,
   input  logic        [SIGNAL_SIZE-2:0] err_th,
   input  logic signed [9:0]             NI_start,
   input  logic signed [9:0]             NI_final,
   input  logic        [CW-1:0]          t_dwell,
   input  logic        [CW-1:0]          t_unlock,
   input  logic        [CW-1:0]          t_wait,
   output logic                          on,
   output logic                          hold,
   output logic signed [9:0]             NI,
   output logic                          locked,
   output logic        [2:0]             state,
   output logic        [7:0]             relock_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RAMP   = 3'd1,
      ST_LOCKED = 3'd2,
      ST_HOLD   = 3'd3,
      ST_CLEAR  = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic signed [9:0]       ni_q, ni_d;
   logic        [CW-1:0]    dwell_q, dwell_d;
   logic        [CW-1:0]    unlock_q, unlock_d;
   logic        [CW-1:0]    wait_q, wait_d;
   logic        [7:0]       relock_q, relock_d;
   logic                    on_q, on_d;
   logic                    hold_q, hold_d;
   logic                    locked_q, locked_d;

   logic signed [9:0]             ni_min;
   logic        [SIGNAL_SIZE-1:0] err_mag;
   logic                          bad;
   logic        [CW-1:0]          dwell_eff, unlock_eff, wait_eff;
   logic        [CW:0]            dwell_inc, unlock_inc, wait_inc;
   logic                          dwell_hit, unlock_hit, wait_hit;
   logic signed [10:0]            ni_cur_x, ni_final_x, ni_stepped;
   logic signed [9:0]             ni_ramp_next;

   assign ni_min = (NI_start < NI_final) ? NI_start : NI_final;

   // Magnitude kept at full width so the most negative error maps to 2^(SS-1),
   // which lies above every representable threshold.
   assign err_mag = s_err[SIGNAL_SIZE-1] ? $unsigned(-s_err) : $unsigned(s_err);
   assign bad     = (s_out >= UL) | (s_out <= LL) | (err_mag > {1'b0, err_th});

   assign dwell_eff  = (t_dwell  == '0) ? CW'(1) : t_dwell;
   assign unlock_eff = (t_unlock == '0) ? CW'(1) : t_unlock;
   assign wait_eff   = (t_wait   == '0) ? CW'(1) : t_wait;

   assign dwell_inc  = {1'b0, dwell_q}  + {{CW{1'b0}}, 1'b1};
   assign unlock_inc = {1'b0, unlock_q} + {{CW{1'b0}}, 1'b1};
   assign wait_inc   = {1'b0, wait_q}   + {{CW{1'b0}}, 1'b1};

   assign dwell_hit  = dwell_inc  >= {1'b0, dwell_eff};
   assign unlock_hit = unlock_inc >= {1'b0, unlock_eff};
   assign wait_hit   = wait_inc   >= {1'b0, wait_eff};

   assign ni_cur_x     = {ni_q[9], ni_q};
   assign ni_final_x   = {NI_final[9], NI_final};
   assign ni_stepped   = ni_cur_x + 11'(NI_STEP);
   assign ni_ramp_next = (ni_stepped >= ni_final_x) ? NI_final : ni_stepped[9:0];

   always_comb begin
      state_d  = state_q;
      ni_d     = ni_q;
      dwell_d  = dwell_q;
      unlock_d = unlock_q;
      wait_d   = wait_q;
      relock_d = relock_q;
      if (!enable) begin
         state_d  = ST_IDLE;
         ni_d     = ni_min;
         dwell_d  = '0;
         unlock_d = '0;
         wait_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d  = ST_RAMP;
               ni_d     = ni_min;
               dwell_d  = '0;
               unlock_d = '0;
               wait_d   = '0;
            end
            ST_RAMP: begin
               if (dwell_hit) begin
                  dwell_d = '0;
                  if (ni_q < NI_final) begin
                     ni_d = ni_ramp_next;
                  end else begin
                     ni_d     = NI_final;
                     state_d  = ST_LOCKED;
                     unlock_d = '0;
                  end
               end else begin
                  dwell_d = dwell_inc[CW-1:0];
               end
            end
            ST_LOCKED: begin
               // An unlock reached on the same cycle as hold_req takes precedence.
               if (bad && unlock_hit) begin
                  state_d  = ST_CLEAR;
                  ni_d     = ni_min;
                  unlock_d = '0;
                  wait_d   = '0;
                  relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
               end else begin
                  unlock_d = bad ? unlock_inc[CW-1:0] : '0;
                  if (hold_req) state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!hold_req) state_d = ST_LOCKED;
            end
            ST_CLEAR: begin
               ni_d = ni_min;
               if (wait_hit) begin
                  state_d = ST_RAMP;
                  wait_d  = '0;
                  dwell_d = '0;
               end else begin
                  wait_d = wait_inc[CW-1:0];
               end
            end
            default: begin
               state_d  = ST_IDLE;
               ni_d     = ni_min;
               dwell_d  = '0;
               unlock_d = '0;
               wait_d   = '0;
            end
         endcase
      end
      on_d     = (state_d == ST_RAMP) || (state_d == ST_LOCKED) || (state_d == ST_HOLD);
      hold_d   = (state_d == ST_HOLD);
      locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ni_q     <= NI_start;
         dwell_q  <= '0;
         unlock_q <= '0;
         wait_q   <= '0;
         relock_q <= '0;
         on_q     <= 1'b0;
         hold_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ni_q     <= ni_d;
         dwell_q  <= dwell_d;
         unlock_q <= unlock_d;
         wait_q   <= wait_d;
         relock_q <= relock_d;
         on_q     <= on_d;
         hold_q   <= hold_d;
         locked_q <= locked_d;
      end
   end

   assign on         = on_q;
   assign hold       = hold_q;
   assign NI         = ni_q;
   assign locked     = locked_q;
   assign state      = state_q;
   assign relock_cnt = relock_q;

endmodule

// File: tb/tb_cav_lock_seq.sv
// Bench for cav_lock_seq: phase/timer model checked every cycle plus directed literal checkpoints.
module tb_cav_lock_seq;

   localparam int SS = 25;
   localparam int CW = 20;

   logic                 clk = 1'b0;
   logic                 rst, enable, hold_req;
   logic signed [SS-1:0] s_err, s_out, UL, LL;
   logic        [SS-2:0] err_th;
   logic signed [9:0]    NI_start, NI_final;
   logic        [CW-1:0] t_dwell, t_unlock, t_wait;
   logic                 on, hold, locked;
   logic signed [9:0]    NI;
   logic        [2:0]    state;
   logic        [7:0]    relock_cnt;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: phase number, current gain, elapsed-cycle timers, run length of bad samples.
   int m_phase, m_ni, m_dwell_el, m_bad_run, m_wait_el, m_relocks;

   always #5 clk = ~clk;

   cav_lock_seq #(.SIGNAL_SIZE(SS), .CW(CW), .NI_STEP(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .hold_req(hold_req),
      .s_err(s_err), .s_out(s_out), .UL(UL), .LL(LL), .err_th(err_th),
      .NI_start(NI_start), .NI_final(NI_final),
      .t_dwell(t_dwell), .t_unlock(t_unlock), .t_wait(t_wait),
      .on(on), .hold(hold), .NI(NI), .locked(locked),
      .state(state), .relock_cnt(relock_cnt)
   );

   function automatic int teff(input int t);
      return (t == 0) ? 1 : t;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic bit is_bad();
      longint e, mag;
      e   = s_err;
      mag = (e < 0) ? -e : e;
      return (s_out >= UL) || (s_out <= LL) || (mag > longint'(err_th));
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(posedge clk) begin : model
      int lo;
      lo = imin(NI_start, NI_final);
      if (rst) begin
         m_phase = 0; m_ni = NI_start; m_dwell_el = 0;
         m_bad_run = 0; m_wait_el = 0; m_relocks = 0;
      end else if (!enable) begin
         m_phase = 0; m_ni = lo; m_dwell_el = 0; m_bad_run = 0; m_wait_el = 0;
      end else begin
         case (m_phase)
            0: begin
               m_phase = 1; m_ni = lo; m_dwell_el = 0;
            end
            1: begin
               m_dwell_el++;
               if (m_dwell_el >= teff(t_dwell)) begin
                  m_dwell_el = 0;
                  if (m_ni < NI_final) m_ni = imin(m_ni + 1, NI_final);
                  else begin
                     m_ni = NI_final; m_phase = 2; m_bad_run = 0;
                  end
               end
            end
            2: begin
               m_bad_run = is_bad() ? m_bad_run + 1 : 0;
               if (m_bad_run >= teff(t_unlock)) begin
                  m_phase = 4; m_ni = lo; m_bad_run = 0; m_wait_el = 0;
                  if (m_relocks < 255) m_relocks++;
               end else if (hold_req) m_phase = 3;
            end
            3: if (!hold_req) m_phase = 2;
            4: begin
               m_ni = lo;
               m_wait_el++;
               if (m_wait_el >= teff(t_wait)) begin
                  m_phase = 1; m_dwell_el = 0;
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_state",  state,      m_phase);
         chk("cyc_on",     on,         (m_phase == 1) || (m_phase == 2) || (m_phase == 3));
         chk("cyc_hold",   hold,       m_phase == 3);
         chk("cyc_locked", locked,     (m_phase == 2) || (m_phase == 3));
         chk("cyc_ni",     NI,         m_ni);
         chk("cyc_relock", relock_cnt, m_relocks);
      end
   end

   initial begin
      rst = 1'b1; enable = 1'b0; hold_req = 1'b0;
      s_err = '0; s_out = '0; UL = 1000; LL = -1000; err_th = 500;
      NI_start = -40; NI_final = -32; t_dwell = 4; t_unlock = 8; t_wait = 16;
      @(posedge clk); #1;
      chk_en = 1'b1;
      tick(2);
      chk("rst_state", state, 0);
      chk("rst_on", on, 0);
      chk("rst_hold", hold, 0);
      chk("rst_locked", locked, 0);
      chk("rst_ni", NI, -40);
      chk("rst_relock", relock_cnt, 0);
      rst = 1'b0;
      tick(2);

      // Ramp -40 .. -32, one step per 4 cycles, lock one dwell after reaching final.
      enable = 1'b1;
      tick(1);
      chk("ramp_on", on, 1);
      chk("ramp_state", state, 1);
      chk("ramp_ni0", NI, -40);
      tick(4);
      chk("ramp_ni1", NI, -39);
      tick(31);
      chk("ramp_prelock", locked, 0);
      chk("ramp_ni_final", NI, -32);
      tick(1);
      chk("lock_at_36", locked, 1);
      chk("lock_state", state, 2);

      // Seven rail cycles stay locked; eight unlock.
      s_out = 1000; tick(7); s_out = 0; tick(1);
      chk("seven_bad_locked", state, 2);
      s_out = 1000; tick(7);
      chk("pre_unlock", state, 2);
      tick(1);
      chk("unlock_state", state, 4);
      chk("unlock_on", on, 0);
      chk("unlock_relock", relock_cnt, 1);
      s_out = 0;
      tick(15);
      chk("clear_wait", state, 4);
      tick(1);
      chk("reacq_state", state, 1);
      chk("reacq_ni", NI, -40);
      tick(36);
      chk("relock_state", state, 2);

      // Hold freezes the unlock count at 4; four more bad cycles after release unlock.
      s_out = 1000; tick(3);
      hold_req = 1'b1; tick(1);
      chk("hold_state", state, 3);
      chk("hold_out", hold, 1);
      tick(100);
      chk("hold_no_unlock", state, 3);
      hold_req = 1'b0; tick(1);
      chk("unhold_state", state, 2);
      chk("unhold_hold", hold, 0);
      tick(3);
      chk("resume_locked", state, 2);
      tick(1);
      chk("resume_unlock", state, 4);
      chk("resume_relock", relock_cnt, 2);
      s_out = 0;
      tick(16);
      chk("hold_reacq", state, 1);

      // Enable drop mid-ramp, then coinciding with an unlock.
      tick(5);
      enable = 1'b0; tick(1);
      chk("drop_ramp_state", state, 0);
      chk("drop_ramp_on", on, 0);
      chk("drop_ramp_ni", NI, -40);
      enable = 1'b1; tick(1);
      chk("restart_state", state, 1);
      tick(36);
      chk("restart_lock", state, 2);
      s_out = 1000; tick(7);
      enable = 1'b0; tick(1);
      chk("drop_unlock_state", state, 0);
      chk("drop_unlock_relock", relock_cnt, 2);
      chk("drop_unlock_locked", locked, 0);
      s_out = 0;

      // Start above final: idle gain is the smaller word.
      NI_start = 10; NI_final = 3; tick(1);
      chk("idle_min_ni", NI, 3);

      // Most negative error is bad at the largest threshold; saturate relock count.
      NI_start = 5; NI_final = 5; t_dwell = 1; t_unlock = 1; t_wait = 1;
      err_th = '1; s_err = 25'h1000000;
      tick(1);
      enable = 1'b1; tick(3);
      chk("neg_err_unlock", state, 4);
      chk("neg_err_relock", relock_cnt, 3);
      tick(900);
      chk("relock_sat", relock_cnt, 255);
      s_err = -25'sd16777215;
      tick(5);
      chk("near_neg_locked", state, 2);
      chk("near_neg_flag", locked, 1);
      chk("sat_hold", relock_cnt, 255);

      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
